// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios input PIO: register offsets, edge modes,
// Avalon request payload and the edge-select helper.
package nios_pio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 2;

    // Word offsets of the slave registers
    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

    // Edge types accepted by the EDGE_TYPE parameter
    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // Avalon-MM slave request as seen on one clock edge
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              chipselect;
        logic              write_n;
        logic [BUS_W-1:0]  writedata;
    } avl_req_t;

    // Per-bit edge flags from the previous and current debounced values
    function automatic logic [BUS_W-1:0] edge_select(
        input logic [BUS_W-1:0] prev,
        input logic [BUS_W-1:0] cur,
        input int unsigned      mode
    );
        logic [BUS_W-1:0] flags;
        flags = '0;
        case (mode)
            EDGE_RISING:  flags = cur & ~prev;
            EDGE_FALLING: flags = ~cur & prev;
            default:      flags = cur ^ prev;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/nios_input_debounce.sv
// One input bit: two-flop synchroniser followed by a stable-count debounce
// filter. With DEBOUNCE_CYCLES = 0 the synchroniser output is used directly.
module nios_input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_stable
);

    logic r_sync1;
    logic r_sync2;

    // Two-stage synchroniser for the asynchronous input
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign o_stable = r_sync2;
        end else begin : g_filter
            localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic             r_stable;
            logic [CNT_W-1:0] r_cnt;

            // Accept a new level only after it has differed from the
            // accepted one for DEBOUNCE_CYCLES consecutive edges
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_stable <= 1'b0;
                    r_cnt    <= '0;
                end else if (r_sync2 != r_stable) begin
                    if (r_cnt == CNT_LAST) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign o_stable = r_stable;
        end
    endgenerate

endmodule

// File: rtl/nios_input_pio.sv
// Avalon-MM input PIO: debounced DATA, IRQMASK, edge-capture register with
// write-1-to-clear, and a level interrupt from masked captured edges.
module nios_input_pio
    import nios_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [BUS_W-1:0]  readdata,
    output logic              irq
);

    avl_req_t         w_req;
    logic             w_wr;
    logic             w_wr_mask;
    logic             w_wr_ecap;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_edgecap_next;
    logic [BUS_W-1:0] w_rd_next;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [BUS_W-1:0] r_readdata;

    assign w_req.address    = address;
    assign w_req.chipselect = chipselect;
    assign w_req.write_n    = write_n;
    assign w_req.writedata  = writedata;

    // Write decode; data bits above WIDTH are dropped
    assign w_wr      = w_req.chipselect & ~w_req.write_n;
    assign w_wr_mask = w_wr && (w_req.address == ADDR_IRQMASK);
    assign w_wr_ecap = w_wr && (w_req.address == ADDR_EDGECAP);
    assign w_wdata   = w_req.writedata[WIDTH-1:0];
    assign w_unused_wdata = ^w_req.writedata;

    // Per-bit synchroniser and debounce filter
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
        nios_input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clk   (clk),
            .i_reset (reset),
            .i_async (in_port[gi]),
            .o_stable(w_stable[gi])
        );
    end

    // Edge flags from last cycle's and this cycle's debounced value
    assign w_edge = WIDTH'(edge_select(BUS_W'(r_prev), BUS_W'(w_stable), EDGE_TYPE));

    // Write-1-clear first, then new edges, so a same-edge set wins
    always_comb begin
        w_edgecap_next = r_edgecap;
        if (w_wr_ecap) begin
            w_edgecap_next = w_edgecap_next & ~w_wdata;
        end
        w_edgecap_next = w_edgecap_next | w_edge;
    end

    // Read mux; reserved offset reads zero and bits above WIDTH stay zero
    always_comb begin
        w_rd_next = '0;
        case (w_req.address)
            ADDR_DATA:    w_rd_next = BUS_W'(w_stable);
            ADDR_IRQMASK: w_rd_next = BUS_W'(r_irqmask);
            ADDR_EDGECAP: w_rd_next = BUS_W'(r_edgecap);
            default:      w_rd_next = '0;
        endcase
    end

    // Edge history, mask, capture and read-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
        end else begin
            r_prev     <= w_stable;
            r_edgecap  <= w_edgecap_next;
            r_readdata <= w_rd_next;
            if (w_wr_mask) begin
                r_irqmask <= w_wdata;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios_input_pio.sv
// Bench for nios_input_pio: two configurations share the Avalon bus and are
// compared every cycle against a window-based behavioural model.
module tb_nios_input_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in_a;
    logic [31:0] in_b;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nios_input_pio #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    nios_input_pio #(.WIDTH(32), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    // Reference model: index 0 = dut_a, 1 = dut_b
    int unsigned cfg_w [2] = '{10, 32};
    int unsigned cfg_d [2] = '{4, 0};
    int unsigned cfg_e [2] = '{0, 1};

    logic [31:0] m_s1     [2];
    logic [31:0] m_s2     [2];
    logic [31:0] m_stable [2];
    logic [31:0] m_prev   [2];
    logic [31:0] m_mask   [2];
    logic [31:0] m_ecap   [2];
    logic [31:0] m_rd     [2];
    logic        m_irq    [2];
    logic [31:0] m_hist   [2][32];

    function automatic logic [31:0] wmask(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'(1) << w) - 32'(1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model, using the bus inputs present at that edge
    task automatic model_edge(input int i, input logic [31:0] inv);
        logic [31:0] wm, st_now, edges, w1c, dm;
        logic        wr;
        wm = wmask(cfg_w[i]);
        if (reset) begin
            m_s1[i] = '0; m_s2[i] = '0; m_stable[i] = '0; m_prev[i] = '0;
            m_mask[i] = '0; m_ecap[i] = '0; m_rd[i] = '0;
            for (int b = 0; b < 32; b++) m_hist[i][b] = '0;
        end else begin
            wr = chipselect && !write_n;
            st_now = (cfg_d[i] == 0) ? m_s2[i] : m_stable[i];
            case (cfg_e[i])
                0:       edges = st_now & ~m_prev[i];
                1:       edges = ~st_now & m_prev[i];
                default: edges = st_now ^ m_prev[i];
            endcase
            edges = edges & wm;
            case (address)
                2'd0:    m_rd[i] = st_now;
                2'd2:    m_rd[i] = m_mask[i];
                2'd3:    m_rd[i] = m_ecap[i];
                default: m_rd[i] = '0;
            endcase
            w1c = (wr && address == 2'd3) ? (writedata & wm) : 32'd0;
            if (wr && address == 2'd2) m_mask[i] = writedata & wm;
            m_ecap[i] = (m_ecap[i] & ~w1c) | edges;
            m_prev[i] = st_now;
            // A level is accepted once the last D synchronised samples all disagree with it
            if (cfg_d[i] > 0) begin
                dm = (32'(1) << cfg_d[i]) - 32'(1);
                for (int b = 0; b < int'(cfg_w[i]); b++) begin
                    m_hist[i][b] = {m_hist[i][b][30:0], m_s2[i][b]};
                    if (m_stable[i][b] && ((m_hist[i][b] & dm) == 32'd0))
                        m_stable[i][b] = 1'b0;
                    else if (!m_stable[i][b] && ((m_hist[i][b] & dm) == dm))
                        m_stable[i][b] = 1'b1;
                end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = inv & wm;
        end
        m_irq[i] = |(m_ecap[i] & m_mask[i]);
    endtask

    task automatic step(input int n = 1);
        for (int c = 0; c < n; c++) begin
            logic [31:0] ia, ib;
            ia = 32'(in_a);
            ib = in_b;
            @(posedge clk);
            model_edge(0, ia);
            model_edge(1, ib);
            #1;
            chk("model_rd_a", rd_a, m_rd[0]);
            chk("model_rd_b", rd_b, m_rd[1]);
            chk("model_irq_a", 32'(irq_a), 32'(m_irq[0]));
            chk("model_irq_b", 32'(irq_b), 32'(m_irq[1]));
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
        writedata = '0; in_a = '0; in_b = '0;

        // Reset then read every register
        step(3);
        chk("reset_data", rd_a, 32'd0);
        chk("reset_irq", 32'(irq_a), 32'd0);
        address = 2'd2; step(1); chk("reset_mask", rd_a, 32'd0);
        address = 2'd3; step(1); chk("reset_ecap", rd_a, 32'd0);
        chk("reset_ecap_b", rd_b, 32'd0);
        reset = 1'b0; address = 2'd0;
        step(2);

        // Glitch of 3 cycles is rejected
        in_a = 10'h008; step(3);
        in_a = 10'h000; step(8);
        address = 2'd0; step(1); chk("glitch_data", rd_a, 32'd0);
        address = 2'd3; step(1); chk("glitch_ecap", rd_a, 32'd0);

        // Held level is accepted 5 edges after the first sample
        address = 2'd0; in_a = 10'h008;
        step(6); chk("hold_data_early", rd_a, 32'd0);
        step(1); chk("hold_data", rd_a, 32'h0000_0008);

        // Interrupt on a masked rising edge, cleared by W1C
        bus_write(2'd3, 32'h0000_03FF);
        in_a = 10'h000; step(8);
        bus_write(2'd2, 32'h8000_0008);
        address = 2'd3; in_a = 10'h008;
        step(6); chk("irq_before", 32'(irq_a), 32'd0);
        step(1); chk("irq_set", 32'(irq_a), 32'd1);
        step(1); chk("irq_ecap", rd_a, 32'h0000_0008);
        bus_write(2'd3, 32'h0000_0008);
        chk("irq_cleared", 32'(irq_a), 32'd0);

        // W1C on the same edge as a new capture: set wins
        in_a = 10'h028;
        step(6);
        bus_write(2'd3, 32'h0000_0028);
        address = 2'd3; step(1);
        chk("set_wins", rd_a, 32'h0000_0020);

        // Falling-edge mode, 32 bits, no filter
        in_b = 32'h8000_0000; step(4);
        address = 2'd3; step(1); chk("b_rise_none", rd_b, 32'd0);
        in_b = 32'h0000_0000;
        step(2); chk("b_fall_early", 32'(irq_b), 32'd0);
        step(1); chk("b_fall_irq", 32'(irq_b), 32'd1);
        step(1); chk("b_fall_ecap", rd_b, 32'h8000_0000);
        bus_write(2'd3, 32'h8000_0000);

        // All-ones input keeps upper readdata bits zero
        in_a = 10'h3FF; step(8);
        address = 2'd0; step(1);
        chk("width_data", rd_a, 32'h0000_03FF);
        chk("width_upper", rd_a >> 10, 32'd0);

        // Reset in the middle of debouncing discards the partial count
        in_a = 10'h000; step(8);
        bus_write(2'd3, 32'h0000_03FF);
        in_a = 10'h001; step(4);
        reset = 1'b1; address = 2'd0;
        step(2); chk("mid_reset_data", rd_a, 32'd0);
        reset = 1'b0;
        step(6); chk("post_reset_early", rd_a, 32'd0);
        step(1); chk("post_reset_data", rd_a, 32'h0000_0001);
        address = 2'd3; step(1); chk("post_reset_ecap", rd_a, 32'h0000_0001);

        // Random traffic against the model
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 5) == 0) in_a = in_a ^ 10'(1 << $urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) in_b = in_b ^ (32'(1) << $urandom_range(0, 31));
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = ($urandom_range(0, 1) == 0);
            writedata  = $urandom();
            reset      = ($urandom_range(0, 99) == 0);
            step(1);
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_input_pio.md
# nios_input_pio

Parametrised Avalon-MM input port for the Nios system: successor to the fixed 10-bit switch reader. Samples WIDTH asynchronous inputs (switches, keys) through a 2-flop synchroniser and per-bit debounce filter, and exposes the debounced value. Also provides a per-bit edge-capture register with configurable edge type and a maskable level interrupt to the Nios IRQ line.

## Interface
- WIDTH, 10, number of input bits (1..32)
- DEBOUNCE_CYCLES, 4, stable cycles required before a bit change is accepted; 0 = filter bypassed
- EDGE_TYPE, 0, edges captured: 0 rising, 1 falling, 2 any
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- in_port  in  WIDTH  raw asynchronous inputs
- readdata  out  32  registered read data; bits above WIDTH always 0
- irq  out  1  level interrupt, high while any (edgecapture & irqmask) bit is set

## Operation
- Register map (word address): 0 DATA (RO, debounced value); 1 reserved (reads 0, writes ignored); 2 IRQMASK (RW, WIDTH bits); 3 EDGECAPTURE (read; write-1-to-clear).
- Write occurs on a clk edge with chipselect=1 and write_n=0; writes to address 0/1 are ignored; writedata bits ≥ WIDTH are ignored.
- Synchroniser: two flops per bit, reset to 0.
- Debounce, per bit: stable register plus counter of width clog2(DEBOUNCE_CYCLES+1). If sync ≠ stable, counter increments; if sync = stable, counter clears. When counter = DEBOUNCE_CYCLES-1 and sync ≠ stable, stable ← sync and counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
- Edge detect: prev ← stable each cycle; edge per EDGE_TYPE from (prev, stable); a detected edge sets the EDGECAPTURE bit.
- Simultaneous edge and write-1-clear on the same bit: set wins, and the bit stays 1. Other bits clear normally.
- readdata is updated every cycle from address, independent of chipselect, matching the existing read-latency-1 slave convention.
- Reset values: all sync, stable, and prev flops 0; counters 0; IRQMASK 0; EDGECAPTURE 0; readdata 0; irq 0.
- Reset mid-debounce discards the partial count. After reset, an input already held high is re-accepted as a fresh 0→1 change. This sets EDGECAPTURE for rising/any mode, which is intended.

## Timing
- in_port change sampled at edge k → sync output at edge k+1 → stable at edge k+1+DEBOUNCE_CYCLES (k+1 when bypassed).
- EDGECAPTURE bit set one edge after stable changes. irq is combinational from EDGECAPTURE/IRQMASK, so it rises in that same cycle.
- Read: address valid at edge m → readdata reflects register contents before edge m, valid after edge m (latency 1).
- IRQMASK or EDGECAPTURE write at edge m → new value visible on irq after edge m, and in readdata from a read at edge m+1.
- No wait states; no read side effects.

## Structure
- Shared package/header nios_pio_pkg: register offsets (ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3), EDGE_RISING/FALLING/ANY constants.
- Sub-module nios_input_debounce: one bit with synchroniser, debounce counter, and stable output. It takes parameter DEBOUNCE_CYCLES and is instantiated WIDTH times by a generate loop.
- Top holds the edge detect, IRQMASK, EDGECAPTURE, read mux, and readdata register.

## Test plan
Configuration for all scenarios: WIDTH=10, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated.
- Reset then read: hold reset 3 cycles with in_port=0 → readdata=0 at address 0, 2, and 3; irq=0.
- Glitch rejection: pulse in_port[3] high for 3 cycles → DATA stays 0x000 and EDGECAPTURE stays 0. Then hold it high for 6 cycles → DATA=0x008 exactly 5 edges after the first sample.
- Interrupt: write IRQMASK=0x008; raise in_port[3] → EDGECAPTURE=0x008 and irq=1. Write 0x008 to address 3 → irq=0 after that edge.
- Set-wins collision: time a W1C of bit 5 on the same edge as a new bit-5 rising edge → EDGECAPTURE[5] remains 1.
- Edge mode and width: EDGE_TYPE=1, WIDTH=32, DEBOUNCE_CYCLES=0 → falling in_port[31] sets EDGECAPTURE=0x8000_0000 two edges after sampling; a rising edge captures nothing. With WIDTH=10, readdata[31:10] stays 0 under all-ones input.
- Reset mid-debounce: assert reset after 2 of 4 stable cycles with input held high → DATA=0 during reset. DATA becomes 1 five edges after reset release, and EDGECAPTURE sets on the next edge.
